// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC generator.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_FETCH  = 2'd1,
        S_BUBBLE = 2'd2
    } fetch_state_t;

    localparam int PC_INCR = 4;

    typedef logic [3:0] bubble_cnt_t;

endpackage

// File: rtl/fetch_pc_unit_bubble_counter.sv
// Down-counter tracking remaining bubble cycles after a redirect.
// Load has priority; decrement is ignored while frozen or already at zero.
module bubble_counter
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       freeze,
    input  logic       dec,
    output logic       zero
);

    bubble_cnt_t count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !freeze && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program-counter generator: sequential increment, stall hold,
// branch redirect with bubble insertion. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH      = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
    parameter int                  BUBBLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                if_valid,
    output logic                ifid_enable,
    output logic                misalign_err
);

    // The counter holds cycles remaining *after* the current bubble cycle.
    localparam logic [3:0] BUBBLE_LOAD = (BUBBLE_CYCLES > 0) ? 4'(BUBBLE_CYCLES - 1) : 4'd0;

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] target_aligned;
    logic                if_valid_next;
    logic                take_redirect;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;

    assign pc_plus4       = pc + PC_WIDTH'(PC_INCR);
    assign ifid_enable    = ~stall | redirect_valid;
    assign target_aligned = {redirect_target[PC_WIDTH-1:2], 2'b00};

    bubble_counter u_bubble_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (BUBBLE_LOAD),
        .freeze     (stall),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RESET;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            if_valid <= if_valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        if_valid_next = if_valid;
        take_redirect = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        case (state)
            S_RESET: begin
                if (redirect_valid) begin
                    take_redirect = 1'b1;
                end else begin
                    state_next    = S_FETCH;
                    if_valid_next = 1'b1;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    take_redirect = 1'b1;
                end else if (!stall) begin
                    pc_next = pc_plus4;
                end
            end
            S_BUBBLE: begin
                if (redirect_valid) begin
                    take_redirect = 1'b1;
                end else if (!stall) begin
                    if (cnt_zero) begin
                        state_next    = S_FETCH;
                        if_valid_next = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = S_RESET;
                if_valid_next = 1'b0;
            end
        endcase

        // A redirect behaves identically from every state.
        if (take_redirect) begin
            pc_next = target_aligned;
            if (BUBBLE_CYCLES > 0) begin
                state_next    = S_BUBBLE;
                if_valid_next = 1'b0;
                cnt_load      = 1'b1;
            end else begin
                state_next    = S_FETCH;
                if_valid_next = 1'b1;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    logic unused_target_bits;
    assign unused_target_bits = ^redirect_target[1:0];
    assign misalign_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_fetch_pc_unit;

    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          redirect_valid;
    logic [PW-1:0] redirect_target;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_plus4;
    logic          if_valid;
    logic          ifid_enable;
    logic          misalign_err;

    typedef struct {
        logic [PW-1:0] pc;
        logic          if_valid;
        logic          ifid_enable;
        logic          misalign;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic M = 1'b1;
`else
    localparam logic M = 1'b0;
`endif

    fetch_pc_unit #(
        .PC_WIDTH      (PW),
        .RESET_PC      (64'h0),
        .BUBBLE_CYCLES (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .if_valid        (if_valid),
        .ifid_enable     (ifid_enable),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Inputs for this cycle are applied just after the edge; the expected
    // outputs are what the DUT should show during the same cycle.
    task automatic step(input logic r, input logic st, input logic rv, input logic [PW-1:0] tgt,
                        input logic [PW-1:0] epc, input logic ev, input logic eife, input logic emis);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = r;
        stall           = st;
        redirect_valid  = rv;
        redirect_target = tgt;
        e.pc          = epc;
        e.if_valid    = ev;
        e.ifid_enable = eife;
        e.misalign    = emis;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc",           pc,                 e.pc);
            check("pc_plus4",     pc_plus4,           e.pc + 64'd4);
            check("if_valid",     PW'(if_valid),      PW'(e.if_valid));
            check("ifid_enable",  PW'(ifid_enable),   PW'(e.ifid_enable));
            check("misalign_err", PW'(misalign_err),  PW'(e.misalign));
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        repeat (2) @(posedge clk);

        //   rst st rv target                    pc                        v  ife mis
        step(0, 0, 0, 64'h0,                     64'h0,                    0, 1, 0);
        step(0, 0, 0, 64'h0,                     64'h0,                    1, 1, 0);
        step(0, 0, 0, 64'h0,                     64'h4,                    1, 1, 0);
        step(0, 1, 0, 64'h0,                     64'h8,                    1, 0, 0);
        step(0, 1, 0, 64'h0,                     64'h8,                    1, 0, 0);
        step(0, 1, 0, 64'h0,                     64'h8,                    1, 0, 0);
        step(0, 0, 0, 64'h0,                     64'h8,                    1, 1, 0);
        step(0, 0, 1, 64'h100,                   64'hC,                    1, 1, 0);
        step(0, 0, 0, 64'h0,                     64'h100,                  0, 1, 0);
        step(0, 0, 0, 64'h0,                     64'h100,                  1, 1, 0);
        step(0, 1, 1, 64'h200,                   64'h104,                  1, 1, 0);
        step(0, 1, 0, 64'h0,                     64'h200,                  0, 0, 0);
        step(0, 1, 0, 64'h0,                     64'h200,                  0, 0, 0);
        step(0, 0, 0, 64'h0,                     64'h200,                  0, 1, 0);
        step(0, 0, 0, 64'h0,                     64'h200,                  1, 1, 0);
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC,   64'h204,                  1, 1, 0);
        step(0, 0, 0, 64'h0,                     64'hFFFF_FFFF_FFFF_FFFC,  0, 1, 0);
        step(0, 0, 0, 64'h0,                     64'hFFFF_FFFF_FFFF_FFFC,  1, 1, 0);
        step(0, 0, 1, 64'h103,                   64'h0,                    1, 1, 0);
        step(0, 0, 0, 64'h0,                     64'h100,                  0, 1, M);
        step(0, 0, 0, 64'h0,                     64'h100,                  1, 1, M);
        step(0, 0, 0, 64'h0,                     64'h104,                  1, 1, M);
        step(1, 0, 0, 64'h0,                     64'h108,                  1, 1, M);
        step(0, 0, 0, 64'h0,                     64'h0,                    0, 1, 0);
        step(0, 0, 0, 64'h0,                     64'h0,                    1, 1, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", PW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
